// File: rtl/board_writer.sv
// Board-state owner: accepts from/to move requests, validates them, and applies lift/capture/place
// with pawn promotion before handing the turn to the other side.
module board_writer #(
  parameter logic       START_COLOR   = 1'b0,
  parameter logic [2:0] PROMO_DEFAULT = 3'b101
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  newGame,
  input  logic                  moveValid,
  output logic                  moveReady,
  input  logic [2:0]            fromRow,
  input  logic [2:0]            fromCol,
  input  logic [2:0]            toRow,
  input  logic [2:0]            toCol,
  input  logic [2:0]            promoType,
  output logic [7:0][7:0][4:0]  boardPos,
  output logic                  turn,
  output logic                  moveDone,
  output logic                  moveErr,
  output logic                  capValid,
  output logic [4:0]            captured
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LIFT, S_PLACE, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [7:0][7:0][4:0] r_board;
  logic                 r_turn;
  logic [2:0]           r_fr, r_fc, r_tr, r_tc, r_promo;
  logic                 r_err;
  logic [4:0]           r_piece;
  logic [4:0]           r_cap;
  logic                 r_capv;

  logic [4:0]           w_from, w_to, w_placed;
  logic                 w_bad, w_promote, w_promo_ok;

  function automatic logic [7:0][7:0][4:0] start_pos();
    logic [7:0][2:0]      back;
    logic [7:0][7:0][4:0] b;
    back[0] = 3'b100; back[1] = 3'b010; back[2] = 3'b011; back[3] = 3'b101;
    back[4] = 3'b110; back[5] = 3'b011; back[6] = 3'b010; back[7] = 3'b100;
    b = '0;
    for (int unsigned c = 0; c < 8; c++) begin
      b[0][c[2:0]] = {back[c[2:0]], 2'b11};
      b[1][c[2:0]] = 5'b00111;
      b[6][c[2:0]] = 5'b00101;
      b[7][c[2:0]] = {back[c[2:0]], 2'b01};
    end
    return b;
  endfunction

  always_comb begin
    w_from     = r_board[r_fr][r_fc];
    w_to       = r_board[r_tr][r_tc];
    w_bad      = ~w_from[0] | (w_from[1] != r_turn) | ({r_fr, r_fc} == {r_tr, r_tc}) |
                 (w_to[0] & (w_to[1] == w_from[1]));
    // Promotion rank depends on the lifted piece's colour, not on whose turn it is.
    w_promote  = (r_piece[4:2] == 3'b001) &&
                 ((!r_piece[1] && r_tr == 3'd0) || (r_piece[1] && r_tr == 3'd7));
    w_promo_ok = (r_promo >= 3'b010) && (r_promo <= 3'b101);
    w_placed   = r_piece;
    if (w_promote)
      w_placed = {(w_promo_ok ? r_promo : PROMO_DEFAULT), r_piece[1], 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    moveReady = 1'b0;
    moveDone  = 1'b0;
    moveErr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        moveReady = 1'b1;
        if (!newGame && moveValid) w_next = S_CHECK;
      end
      S_CHECK: w_next = w_bad ? S_DONE : S_LIFT;
      S_LIFT:  w_next = S_PLACE;
      S_PLACE: w_next = S_DONE;
      S_DONE: begin
        moveDone = ~r_err;
        moveErr  = r_err;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_board <= start_pos();
      r_turn  <= START_COLOR;
      r_fr    <= '0;
      r_fc    <= '0;
      r_tr    <= '0;
      r_tc    <= '0;
      r_promo <= '0;
      r_err   <= 1'b0;
      r_piece <= '0;
      r_cap   <= '0;
      r_capv  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_err <= 1'b0;
          if (newGame) begin
            r_board <= start_pos();
            r_turn  <= START_COLOR;
          end else if (moveValid) begin
            r_fr    <= fromRow;
            r_fc    <= fromCol;
            r_tr    <= toRow;
            r_tc    <= toCol;
            r_promo <= promoType;
          end
        end
        S_CHECK: r_err <= w_bad;
        S_LIFT: begin
          r_cap                <= w_to;
          r_capv               <= w_to[0];
          r_piece              <= w_from;
          r_board[r_fr][r_fc]  <= '0;
        end
        S_PLACE: r_board[r_tr][r_tc] <= w_placed;
        S_DONE: begin
          if (!r_err) r_turn <= ~r_turn;
          r_cap  <= '0;
          r_capv <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign boardPos = r_board;
  assign turn     = r_turn;
  assign captured = r_cap;
  assign capValid = r_capv;

endmodule

// File: tb/tb_board_writer.sv
// Scoreboard bench for board_writer: directed moves push expectations, a monitor checks each done/err pulse.
module tb_board_writer;
  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 newGame = 1'b0;
  logic                 moveValid = 1'b0;
  logic                 moveReady;
  logic [2:0]           fromRow = '0, fromCol = '0, toRow = '0, toCol = '0, promoType = '0;
  logic [7:0][7:0][4:0] boardPos;
  logic                 turn, moveDone, moveErr, capValid;
  logic [4:0]           captured;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit         ok;
    int         lat;
    int         acc;
    bit         capv;
    logic [4:0] cap;
    logic [2:0] fr, fc, tr, tc;
    logic [4:0] to_v, from_v;
  } exp_t;
  exp_t q[$];

  board_writer #(.START_COLOR(1'b0), .PROMO_DEFAULT(3'b101)) dut (
    .clk(clk), .reset(reset), .newGame(newGame), .moveValid(moveValid), .moveReady(moveReady),
    .fromRow(fromRow), .fromCol(fromCol), .toRow(toRow), .toCol(toCol), .promoType(promoType),
    .boardPos(boardPos), .turn(turn), .moveDone(moveDone), .moveErr(moveErr),
    .capValid(capValid), .captured(captured)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && (moveDone || moveErr)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%0b%0b required=00", moveDone, moveErr);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_err", {30'd0, moveDone, moveErr}, e.ok ? 32'd2 : 32'd1);
        chk("latency", cyc - e.acc, e.lat);
        chk("capValid", {31'd0, capValid}, {31'd0, e.capv});
        if (e.capv) chk("captured", {27'd0, captured}, {27'd0, e.cap});
        chk("to_square", {27'd0, boardPos[e.tr][e.tc]}, {27'd0, e.to_v});
        chk("from_square", {27'd0, boardPos[e.fr][e.fc]}, {27'd0, e.from_v});
      end
    end
  end

  task automatic do_move(input logic [2:0] fr, fc, tr, tc, pr, input bit ok, input bit capv,
                         input logic [4:0] cap, to_v, from_v, input logic exp_turn);
    exp_t e;
    bit   back;
    @(negedge clk);
    fromRow = fr; fromCol = fc; toRow = tr; toCol = tc; promoType = pr; moveValid = 1'b1;
    e.ok = ok; e.lat = ok ? 4 : 2; e.acc = cyc; e.capv = capv; e.cap = cap;
    e.fr = fr; e.fc = fc; e.tr = tr; e.tc = tc; e.to_v = to_v; e.from_v = from_v;
    q.push_back(e);
    @(negedge clk);
    moveValid = 1'b0;
    fromRow = ~fr; fromCol = ~fc; toRow = ~tr; toCol = ~tc; promoType = 3'b011;
    back = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (moveReady) begin back = 1'b1; break; end
    end
    chk("ready_return", {31'd0, back}, 32'd1);
    chk("turn_after", {31'd0, turn}, {31'd0, exp_turn});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_e2", {27'd0, boardPos[6][4]}, 32'h05);
    chk("rst_king", {27'd0, boardPos[0][4]}, 32'h1B);
    chk("rst_rook_w", {27'd0, boardPos[7][0]}, 32'h11);
    chk("rst_turn", {31'd0, turn}, 32'd0);
    chk("rst_ready", {31'd0, moveReady}, 32'd1);
    chk("rst_pulses", {28'd0, moveDone, moveErr, capValid, |captured}, 32'd0);

    //      fr  fc  tr  tc  promo   ok  capv cap      to       from     turn
    do_move(6,  4,  4,  4,  3'b000, 1,  0,   5'h00,   5'h05,   5'h00,   1'b1); // white e2-e4
    do_move(6,  3,  5,  3,  3'b000, 0,  0,   5'h00,   5'h00,   5'h05,   1'b1); // white while black to move
    do_move(0,  1,  2,  2,  3'b000, 1,  0,   5'h00,   5'h0B,   5'h00,   1'b0); // black knight out
    do_move(6,  0,  1,  0,  3'b000, 1,  1,   5'h07,   5'h05,   5'h00,   1'b1); // white pawn takes (1,0)
    do_move(0,  0,  0,  1,  3'b000, 1,  0,   5'h00,   5'h13,   5'h00,   1'b0); // black rook to (0,1)
    do_move(1,  0,  0,  1,  3'b111, 1,  1,   5'h13,   5'h15,   5'h00,   1'b1); // promo, bad type -> queen
    do_move(0,  4,  0,  4,  3'b000, 0,  0,   5'h00,   5'h1B,   5'h1B,   1'b1); // from == to
    do_move(3,  3,  4,  3,  3'b000, 0,  0,   5'h00,   5'h00,   5'h00,   1'b1); // empty from
    do_move(0,  3,  0,  2,  3'b000, 0,  0,   5'h00,   5'h0F,   5'h17,   1'b1); // own piece on to
    do_move(1,  7,  7,  7,  3'b010, 1,  1,   5'h11,   5'h0B,   5'h00,   1'b0); // black promo to knight
    do_move(0,  4,  1,  4,  3'b000, 0,  0,   5'h00,   5'h07,   5'h1B,   1'b0); // wrong colour piece

    // Reset while the move sits in LIFT: start position at once, no pulse afterwards.
    @(negedge clk);
    fromRow = 6; fromCol = 5; toRow = 4; toCol = 5; promoType = 0; moveValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    moveValid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_knight", {27'd0, boardPos[0][1]}, 32'h0B);
    chk("mid_rst_rook", {27'd0, boardPos[7][7]}, 32'h11);
    chk("mid_rst_from", {27'd0, boardPos[6][5]}, 32'h05);
    chk("mid_rst_turn", {31'd0, turn}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, moveReady}, 32'd1);
    repeat (6) @(negedge clk);
    chk("mid_rst_to", {27'd0, boardPos[4][5]}, 32'h00);

    do_move(6,  7,  5,  7,  3'b000, 1,  0,   5'h00,   5'h05,   5'h00,   1'b1);

    // newGame beats moveValid: reload, request dropped.
    @(negedge clk);
    newGame = 1'b1; moveValid = 1'b1;
    fromRow = 6; fromCol = 4; toRow = 4; toCol = 4; promoType = 0;
    @(posedge clk);
    #1;
    chk("ng_ready", {31'd0, moveReady}, 32'd1);
    chk("ng_moved_sq", {27'd0, boardPos[5][7]}, 32'h00);
    chk("ng_pawn", {27'd0, boardPos[6][7]}, 32'h05);
    chk("ng_turn", {31'd0, turn}, 32'd0);
    @(negedge clk);
    newGame = 1'b0; moveValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ng_ready_hold", {31'd0, moveReady}, 32'd1);
    end
    chk("ng_e2", {27'd0, boardPos[6][4]}, 32'h05);

    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
